// File: rtl/pipe_ctrl_pkg.sv
// Shared widths, stall vector constants, FSM encodings and recovery record for pipe_ctrl.
package pipe_ctrl_pkg;

  localparam int unsigned STALL_W    = 6;
  localparam int unsigned EXC_CODE_W = 5;
  localparam int unsigned PC_W       = 32;
  localparam int unsigned CNT_W      = 32;
  localparam int unsigned FCNT_W     = 2;

  typedef logic [STALL_W-1:0]    stall_bus_t;
  typedef logic [EXC_CODE_W-1:0] exc_code_t;

  localparam stall_bus_t STALL_NONE = 6'b000000;
  localparam stall_bus_t STALL_ID   = 6'b000111;
  localparam stall_bus_t STALL_EXE  = 6'b001111;
  localparam stall_bus_t STALL_MEM  = 6'b011111;
  localparam stall_bus_t STALL_ALL  = 6'b111111;

  localparam logic [1:0] CTRL_RUN   = 2'd0;
  localparam logic [1:0] CTRL_DRAIN = 2'd1;
  localparam logic [1:0] CTRL_FLUSH = 2'd2;

  localparam logic [PC_W-1:0] EXC_VECTOR_DEF = 32'hBFC0_0380;

  // Everything captured from the committing instruction at exception time.
  typedef struct packed {
    logic [PC_W-1:0] target;
    exc_code_t       code;
    logic            eret;
  } recov_t;

  // Merge stage stall requests; the deepest requesting stage wins.
  function automatic stall_bus_t stall_merge(input logic req_id, input logic req_exe,
                                             input logic req_mem);
    if (req_mem)      return STALL_MEM;
    else if (req_exe) return STALL_EXE;
    else if (req_id)  return STALL_ID;
    else              return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stall_counter.sv
// Free-running wrapping counter of cycles in which the PC is held.
module pipe_ctrl_stall_counter
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned W = CNT_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en) cnt_d = cnt_q + W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: merges stage stalls and runs the freeze/drain/flush/redirect
// sequence for exceptions and ERET.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR   = EXC_VECTOR_DEF,
  parameter int unsigned FLUSH_CYCLES = 1
) (
  input  logic                  cpu_clk_50M,
  input  logic                  cpu_rst_n,
  input  logic                  stallreq_id,
  input  logic                  stallreq_exe,
  input  logic                  stallreq_mem,
  input  logic                  exc_valid,
  input  logic                  exc_is_eret,
  input  logic [EXC_CODE_W-1:0] exc_code,
  input  logic [PC_W-1:0]       cp0_epc,
  output logic [STALL_W-1:0]    stall,
  output logic                  flush,
  output logic                  newpc_valid,
  output logic [PC_W-1:0]       cpu_newpc,
  output logic                  cp0_cause_we,
  output logic [EXC_CODE_W-1:0] cp0_exccode,
  output logic [CNT_W-1:0]      stall_cycles
);

  localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FLUSH_CYCLES - 1);

  logic [1:0]            state_q, state_d;
  logic [FCNT_W-1:0]     fcnt_q, fcnt_d;
  recov_t                rec_q, rec_d;
  logic                  flush_q, flush_d;
  logic                  newpc_valid_q, newpc_valid_d;
  logic [PC_W-1:0]       cpu_newpc_q, cpu_newpc_d;
  logic                  cause_we_q, cause_we_d;
  logic [EXC_CODE_W-1:0] exccode_q, exccode_d;

  // Next state, recovery latch and flush down-counter; outputs decoded from next state.
  always_comb begin
    state_d       = state_q;
    fcnt_d        = fcnt_q;
    rec_d         = rec_q;
    flush_d       = 1'b0;
    newpc_valid_d = 1'b0;
    cpu_newpc_d   = '0;
    cause_we_d    = 1'b0;
    exccode_d     = '0;

    case (state_q)
      CTRL_RUN: begin
        if (exc_valid) begin
          rec_d.target = exc_is_eret ? cp0_epc : EXC_VECTOR;
          rec_d.code   = exc_code;
          rec_d.eret   = exc_is_eret;
          fcnt_d       = FCNT_LAST;
          state_d      = stallreq_mem ? CTRL_DRAIN : CTRL_FLUSH;
        end
      end
      CTRL_DRAIN: begin
        if (!stallreq_mem) begin
          fcnt_d  = FCNT_LAST;
          state_d = CTRL_FLUSH;
        end
      end
      CTRL_FLUSH: begin
        if (fcnt_q == '0) state_d = CTRL_RUN;
        else              fcnt_d  = FCNT_W'(fcnt_q - FCNT_W'(1));
      end
      default: state_d = CTRL_RUN;
    endcase

    flush_d       = (state_d == CTRL_FLUSH);
    newpc_valid_d = flush_d && (fcnt_d == '0);
    cause_we_d    = flush_d && (fcnt_d == FCNT_LAST) && !rec_d.eret;
    if (newpc_valid_d) cpu_newpc_d = rec_d.target;
    if (cause_we_d)    exccode_d   = rec_d.code;
  end

  always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
    if (!cpu_rst_n) begin
      state_q       <= CTRL_RUN;
      fcnt_q        <= '0;
      rec_q         <= '0;
      flush_q       <= 1'b0;
      newpc_valid_q <= 1'b0;
      cpu_newpc_q   <= '0;
      cause_we_q    <= 1'b0;
      exccode_q     <= '0;
    end else begin
      state_q       <= state_d;
      fcnt_q        <= fcnt_d;
      rec_q         <= rec_d;
      flush_q       <= flush_d;
      newpc_valid_q <= newpc_valid_d;
      cpu_newpc_q   <= cpu_newpc_d;
      cause_we_q    <= cause_we_d;
      exccode_q     <= exccode_d;
    end
  end

  // Freeze is combinational so an exception holds the whole pipe in its own cycle.
  always_comb begin
    stall = STALL_NONE;
    if (cpu_rst_n) begin
      case (state_q)
        CTRL_RUN:   stall = exc_valid ? STALL_ALL
                                      : stall_merge(stallreq_id, stallreq_exe, stallreq_mem);
        CTRL_DRAIN: stall = STALL_ALL;
        default:    stall = STALL_NONE;
      endcase
    end
  end

  assign flush        = flush_q;
  assign newpc_valid  = newpc_valid_q;
  assign cpu_newpc    = cpu_newpc_q;
  assign cp0_cause_we = cause_we_q;
  assign cp0_exccode  = exccode_q;

  pipe_ctrl_stall_counter #(.W(CNT_W)) u_stall_counter (
    .clk   (cpu_clk_50M),
    .rst_n (cpu_rst_n),
    .en    (stall[0]),
    .count (stall_cycles)
  );

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: two instances (1 and 3 flush cycles) against a reference model.
module tb_pipe_ctrl;

  localparam logic [31:0] VEC = 32'hBFC0_0380;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_id, req_exe, req_mem, exc, eret;
  logic [4:0]  code;
  logic [31:0] epc;

  logic [5:0]  a_stall [2];
  logic        a_flush [2];
  logic        a_nv    [2];
  logic [31:0] a_pc    [2];
  logic        a_we    [2];
  logic [4:0]  a_code  [2];
  logic [31:0] a_cnt   [2];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1)) dut0 (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .stallreq_id(req_id), .stallreq_exe(req_exe),
    .stallreq_mem(req_mem), .exc_valid(exc), .exc_is_eret(eret), .exc_code(code),
    .cp0_epc(epc), .stall(a_stall[0]), .flush(a_flush[0]), .newpc_valid(a_nv[0]),
    .cpu_newpc(a_pc[0]), .cp0_cause_we(a_we[0]), .cp0_exccode(a_code[0]),
    .stall_cycles(a_cnt[0]));

  pipe_ctrl #(.FLUSH_CYCLES(3)) dut1 (
    .cpu_clk_50M(clk), .cpu_rst_n(rst_n), .stallreq_id(req_id), .stallreq_exe(req_exe),
    .stallreq_mem(req_mem), .exc_valid(exc), .exc_is_eret(eret), .exc_code(code),
    .cp0_epc(epc), .stall(a_stall[1]), .flush(a_flush[1]), .newpc_valid(a_nv[1]),
    .cpu_newpc(a_pc[1]), .cp0_cause_we(a_we[1]), .cp0_exccode(a_code[1]),
    .stall_cycles(a_cnt[1]));

  // Reference model: recovery phase (0 idle, 1 waiting on memory, 2 flushing)
  // with flush cycles counted upward.
  int          fc [2] = '{1, 3};
  int          m_mode [2];
  int          m_fidx [2];
  logic [31:0] m_tgt [2];
  logic [4:0]  m_code [2];
  logic        m_eret [2];
  logic        e_flush [2], e_nv [2], e_we [2];
  logic [31:0] e_pc [2], e_cnt [2];
  logic [4:0]  e_code [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_mode[k] = 0; m_fidx[k] = 0; m_tgt[k] = '0; m_code[k] = '0; m_eret[k] = 1'b0;
      e_flush[k] = 1'b0; e_nv[k] = 1'b0; e_we[k] = 1'b0;
      e_pc[k] = '0; e_cnt[k] = '0; e_code[k] = '0;
    end
  endtask

  function automatic logic [5:0] model_stall(input int k);
    if (!rst_n)          return 6'h00;
    if (m_mode[k] == 1)  return 6'h3F;
    if (m_mode[k] == 2)  return 6'h00;
    if (exc)             return 6'h3F;
    if (req_mem)         return 6'h1F;
    if (req_exe)         return 6'h0F;
    if (req_id)          return 6'h07;
    return 6'h00;
  endfunction

  task automatic model_update();
    for (int k = 0; k < 2; k++) begin
      logic [5:0] s;
      s = model_stall(k);
      e_cnt[k] = e_cnt[k] + 32'(s[0]);
      case (m_mode[k])
        0: if (exc) begin
             m_tgt[k] = eret ? epc : VEC; m_code[k] = code; m_eret[k] = eret;
             if (req_mem) m_mode[k] = 1;
             else begin m_mode[k] = 2; m_fidx[k] = 0; end
           end
        1: if (!req_mem) begin m_mode[k] = 2; m_fidx[k] = 0; end
        default: begin
          m_fidx[k]++;
          if (m_fidx[k] == fc[k]) m_mode[k] = 0;
        end
      endcase
      e_flush[k] = (m_mode[k] == 2);
      e_nv[k]    = e_flush[k] && (m_fidx[k] == fc[k] - 1);
      e_we[k]    = e_flush[k] && (m_fidx[k] == 0) && !m_eret[k];
      e_pc[k]    = e_nv[k] ? m_tgt[k] : 32'h0;
      e_code[k]  = e_we[k] ? m_code[k] : 5'h0;
    end
  endtask

  task automatic model_check();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("stall[%0d]", k),  32'(a_stall[k]), 32'(model_stall(k)));
      chk($sformatf("flush[%0d]", k),  32'(a_flush[k]), 32'(e_flush[k]));
      chk($sformatf("newpcv[%0d]", k), 32'(a_nv[k]),    32'(e_nv[k]));
      chk($sformatf("newpc[%0d]", k),  a_pc[k],         e_pc[k]);
      chk($sformatf("causewe[%0d]", k),32'(a_we[k]),    32'(e_we[k]));
      chk($sformatf("exccode[%0d]", k),32'(a_code[k]),  32'(e_code[k]));
      chk($sformatf("stallcyc[%0d]", k), a_cnt[k],      e_cnt[k]);
    end
  endtask

  // Inputs are set at a falling edge; check, clock once, return at the next falling edge.
  task automatic step();
    #1 model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    {req_id, req_exe, req_mem, exc, eret} = '0;
    for (int i = 0; i < n; i++) step();
  endtask

  typedef struct {
    logic       id, exe, mem;
    logic [5:0] exp_stall;
  } vec_t;

  vec_t vecs [6];

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 6'b000111};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 6'b011111};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 6'b001111};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 6'b001111};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 6'b011111};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 6'b000000};

    rst_n = 1'b0;
    {req_id, req_exe, req_mem, exc, eret} = 5'b10010;
    code = 5'h0C; epc = '0;
    model_reset();
    @(negedge clk); @(negedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("reset_stall", 32'(a_stall[k]), 32'h0);
      chk("reset_flush", 32'(a_flush[k]), 32'h0);
      chk("reset_newpc", a_pc[k], 32'h0);
      chk("reset_cnt",   a_cnt[k], 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Stall priority table
    foreach (vecs[i]) begin
      req_id = vecs[i].id; req_exe = vecs[i].exe; req_mem = vecs[i].mem; exc = 1'b0;
      #1 chk($sformatf("vec%0d_stall", i), 32'(a_stall[0]), 32'(vecs[i].exp_stall));
      step();
    end

    // Fault with no memory wait; also exercises the three-cycle flush instance
    {req_id, req_exe, req_mem} = 3'b110; exc = 1'b1; eret = 1'b0; code = 5'h0C;
    #1 chk("exc_freeze", 32'(a_stall[0]), 32'h3F);
    step();
    {req_id, req_exe, req_mem, exc} = '0;
    #1;
    chk("exc_flush",  32'(a_flush[0]), 32'h1);
    chk("exc_newpcv", 32'(a_nv[0]),    32'h1);
    chk("exc_newpc",  a_pc[0],         VEC);
    chk("exc_we",     32'(a_we[0]),    32'h1);
    chk("exc_code",   32'(a_code[0]),  32'h0C);
    chk("fc3_c1",     {a_flush[1], a_nv[1], a_we[1]}, 32'b101);
    step();
    #1;
    chk("exc_done", {a_flush[0], a_nv[0], a_we[0], a_pc[0] != 0, a_code[0] != 0}, 32'h0);
    chk("fc3_c2",   {a_flush[1], a_nv[1], a_we[1]}, 32'b100);
    step();
    #1;
    chk("fc3_c3",   {a_flush[1], a_nv[1], a_we[1]}, 32'b110);
    chk("fc3_pc",   a_pc[1], VEC);
    step();
    #1 chk("fc3_done", 32'(a_flush[1]), 32'h0);
    idle(1);

    // ERET redirects to EPC without touching Cause
    exc = 1'b1; eret = 1'b1; epc = 32'h8000_1234; code = 5'h1F;
    step();
    {exc, eret} = '0;
    #1;
    chk("eret_newpc", a_pc[0], 32'h8000_1234);
    chk("eret_we",    32'(a_we[0]), 32'h0);
    idle(4);

    // Memory wait: drain while the access completes; a second exception is ignored
    exc = 1'b1; eret = 1'b0; code = 5'h04; req_mem = 1'b1;
    step();
    for (int i = 0; i < 3; i++) begin
      exc = (i == 1); eret = (i == 1); code = 5'h1F; epc = 32'h1111_2222;
      req_mem = (i < 2);
      #1;
      chk("drain_stall", 32'(a_stall[0]), 32'h3F);
      chk("drain_flush", 32'(a_flush[0]), 32'h0);
      step();
    end
    {exc, eret, req_mem} = '0;
    #1;
    chk("drain_flush_on", 32'(a_flush[0]), 32'h1);
    chk("drain_newpc",    a_pc[0], VEC);
    chk("drain_code",     32'(a_code[0]), 32'h04);
    step();
    #1 chk("drain_flush_off", 32'(a_flush[0]), 32'h0);
    idle(4);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      req_id  = ($urandom_range(0, 2) == 0);
      req_exe = ($urandom_range(0, 3) == 0);
      req_mem = ($urandom_range(0, 2) == 0);
      exc     = ($urandom_range(0, 6) == 0);
      eret    = $urandom_range(0, 1) == 1;
      code    = 5'($urandom);
      epc     = $urandom;
      step();
    end
    idle(6);

    // Counter wrap from a preloaded value
    force dut0.u_stall_counter.cnt_q = 32'hFFFF_FFFE;
    #1 release dut0.u_stall_counter.cnt_q;
    e_cnt[0] = 32'hFFFF_FFFE;
    req_id = 1'b1;
    step();
    #1 chk("wrap_max", a_cnt[0], 32'hFFFF_FFFF);
    step();
    #1 chk("wrap_zero", a_cnt[0], 32'h0);
    idle(2);

    // Reset in the middle of a three-cycle flush
    exc = 1'b1; eret = 1'b0; code = 5'h0A;
    step();
    exc = 1'b0; req_id = 1'b1;
    #1 chk("rst_pre_flush", 32'(a_flush[1]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst_flush_drop", 32'(a_flush[1]), 32'h0);
    chk("rst_stall_zero", 32'(a_stall[1]), 32'h0);
    chk("rst_newpc_zero", a_pc[1], 32'h0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    idle(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
